// File: rtl/dsm2_modulator.sv
// rtl/dsm2_modulator.sv - second-order delta-sigma modulator with overload recovery
//
// Two cascaded saturating integrators driven by a 1-bit +/-FS feedback.
// A run of RUN_MAX identical output bits is treated as overload: the loop
// is flushed to zero and allowed to settle before dout is marked valid again.
//
// Ports:
//   clock       in   sample-rate clock, posedge
//   reset_n     in   asynchronous active-low reset
//   en          in   clock enable, all state holds when low
//   din[19:0]   in   signed sample, full scale 2^19
//   clr_ovf     in   synchronous clear of ovf (a simultaneous set wins)
//   dout        out  bitstream, 1 = +FS, 0 = -FS
//   dout_valid  out  dout was produced in RUN
//   ovf         out  sticky integrator-saturation flag
//   recover_cnt out  saturating count of overload recoveries

module dsm2_modulator #(
  parameter int IW         = 24,
  parameter int RUN_MAX    = 32,
  parameter int SETTLE_LEN = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic [19:0] din,
  input  logic        clr_ovf,
  output logic        dout,
  output logic        dout_valid,
  output logic        ovf,
  output logic [7:0]  recover_cnt
);

  // Two guard bits so integrator + step never wraps before clamping.
  localparam int W  = IW + 2;
  localparam int RW = $clog2(RUN_MAX + 1);
  localparam int SW = $clog2(SETTLE_LEN + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam logic signed [W-1:0] I_MAX  = W'((64'sd1 <<< (IW - 1)) - 64'sd1);
  localparam logic signed [W-1:0] I_MIN  = W'(-(64'sd1 <<< (IW - 1)));
  localparam logic signed [W-1:0] FB_POS = W'(64'sd524288);
  localparam logic signed [W-1:0] FB_NEG = W'(-64'sd524288);

  logic signed [19:0]   x;
  logic signed [IW-1:0] i1;
  logic signed [IW-1:0] i2;
  logic [1:0]           state;
  logic [RW-1:0]        run_len;
  logic [SW-1:0]        settle_cnt;
  logic                 clamp_q;

  logic signed [W-1:0]  x_w, i1_w, i2_w, fb, d1, d2, s1, s2;
  logic signed [IW-1:0] i1_n, i2_n;
  logic                 clamp1, clamp2, dout_n;

  always_comb begin
    x_w  = {{(W - 20){x[19]}}, x};
    i1_w = {{2{i1[IW-1]}}, i1};
    i2_w = {{2{i2[IW-1]}}, i2};
    fb   = dout ? FB_POS : FB_NEG;
    d1   = x_w - fb;
    d2   = i1_w - fb;
    // Both integrators read the old i1; >>> floors toward -inf.
    s1   = i1_w + (d1 >>> 1);
    s2   = i2_w + (d2 >>> 1);

    i1_n   = s1[IW-1:0];
    clamp1 = 1'b0;
    if (s1 > I_MAX) begin
      i1_n   = I_MAX[IW-1:0];
      clamp1 = 1'b1;
    end else if (s1 < I_MIN) begin
      i1_n   = I_MIN[IW-1:0];
      clamp1 = 1'b1;
    end

    i2_n   = s2[IW-1:0];
    clamp2 = 1'b0;
    if (s2 > I_MAX) begin
      i2_n   = I_MAX[IW-1:0];
      clamp2 = 1'b1;
    end else if (s2 < I_MIN) begin
      i2_n   = I_MIN[IW-1:0];
      clamp2 = 1'b1;
    end

    dout_n = ~i2_n[IW-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x           <= '0;
      i1          <= '0;
      i2          <= '0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      ovf         <= 1'b0;
      recover_cnt <= '0;
      run_len     <= RW'(1);
      state       <= ST_RUN;
      settle_cnt  <= '0;
      clamp_q     <= 1'b0;
    end else if (en) begin
      x          <= $signed(din);
      dout_valid <= (state == ST_RUN);

      // A clamp is flagged one edge after it happens; set beats clear.
      if (clamp_q) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end

      case (state)
        ST_RUN: begin
          i1      <= i1_n;
          i2      <= i2_n;
          dout    <= dout_n;
          clamp_q <= clamp1 | clamp2;
          if (dout_n == dout) begin
            run_len <= run_len + RW'(1);
            if (run_len == RW'(RUN_MAX - 1)) begin
              state <= ST_FLUSH;
            end
          end else begin
            run_len <= RW'(1);
          end
        end
        ST_FLUSH: begin
          i1         <= '0;
          i2         <= '0;
          dout       <= 1'b0;
          run_len    <= RW'(1);
          clamp_q    <= 1'b0;
          settle_cnt <= '0;
          if (recover_cnt != 8'hff) begin
            recover_cnt <= recover_cnt + 8'd1;
          end
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          i1      <= i1_n;
          i2      <= i2_n;
          dout    <= dout_n;
          clamp_q <= clamp1 | clamp2;
          if (settle_cnt == SW'(SETTLE_LEN - 1)) begin
            settle_cnt <= '0;
            run_len    <= RW'(1);
            state      <= ST_RUN;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsm2_modulator.sv
// tb/tb_dsm2_modulator.sv - directed testbench for dsm2_modulator

module tb_dsm2_modulator;

  logic       clock;
  logic       reset_n, en, clr_ovf;
  logic [19:0] din;
  logic       dout, dout_valid, ovf;
  logic [7:0] recover_cnt;

  logic       reset_n21, en21, clr21;
  logic [19:0] din21;
  logic       dout21, dv21, ovf21;
  logic [7:0] rc21;

  int checks = 0;
  int errors = 0;

  dsm2_modulator dut (
    .clock(clock), .reset_n(reset_n), .en(en), .din(din), .clr_ovf(clr_ovf),
    .dout(dout), .dout_valid(dout_valid), .ovf(ovf), .recover_cnt(recover_cnt)
  );

  dsm2_modulator #(.IW(21)) dut21 (
    .clock(clock), .reset_n(reset_n21), .en(en21), .din(din21), .clr_ovf(clr21),
    .dout(dout21), .dout_valid(dv21), .ovf(ovf21), .recover_cnt(rc21)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    en      = 1'b0;
    clr_ovf = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; din = '0; clr_ovf = 1'b0;
    #2;
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %0b expected 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %0b expected 0", dout_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
    checks++; if (recover_cnt !== 8'd0) begin errors++; $display("FAIL reset_recover_cnt: got %0d expected 0", recover_cnt); end
    checks++; if (dut.i1 !== 24'sd0 || dut.i2 !== 24'sd0) begin errors++; $display("FAIL reset_integrators: got i1=%0d i2=%0d expected 0 0", dut.i1, dut.i2); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (dut.i1 !== 24'sd262144) begin errors++; $display("FAIL first_edge_i1: got %0d expected 262144", dut.i1); end
    checks++; if (dut.i2 !== 24'sd262144) begin errors++; $display("FAIL first_edge_i2: got %0d expected 262144", dut.i2); end
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL first_edge_dout: got %0b expected 1", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL first_edge_valid: got %0b expected 1", dout_valid); end
  endtask

  task automatic test_zero_input();
    logic b [1:1024];
    int   ones;
    apply_reset();
    din = '0; en = 1'b1;
    for (int c = 1; c <= 1024; c++) begin
      tick();
      b[c] = dout;
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL zero_valid cycle %0d: got %0b expected 1", c, dout_valid); end
    end
    for (int s = 9; s <= 1024 - 63; s++) begin
      ones = 0;
      for (int k = 0; k < 64; k++) ones += int'(b[s + k]);
      checks++; if (ones < 30 || ones > 34) begin errors++; $display("FAIL zero_window start %0d: got %0d ones expected 30..34", s, ones); end
    end
    checks++; if (recover_cnt !== 8'd0) begin errors++; $display("FAIL zero_recover_cnt: got %0d expected 0", recover_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %0b expected 0", ovf); end
  endtask

  task automatic test_half_scale();
    int ones;
    apply_reset();
    din = 20'h40000; en = 1'b1;
    for (int c = 0; c < 16; c++) tick();
    ones = 0;
    for (int c = 0; c < 256; c++) begin tick(); ones += int'(dout); end
    checks++; if (ones < 186 || ones > 198) begin errors++; $display("FAIL half_pos_ones: got %0d expected 186..198", ones); end
    apply_reset();
    din = 20'hC0000; en = 1'b1;
    for (int c = 0; c < 16; c++) tick();
    ones = 0;
    for (int c = 0; c < 256; c++) begin tick(); ones += int'(dout); end
    checks++; if (ones < 58 || ones > 70) begin errors++; $display("FAIL half_neg_ones: got %0d expected 58..70", ones); end
    checks++; if (recover_cnt !== 8'd0) begin errors++; $display("FAIL half_recover_cnt: got %0d expected 0", recover_cnt); end
  endtask

  task automatic test_enable_gating();
    longint mx, m1, m2, fb, n1, n2;
    logic   md;
    apply_reset();
    din = 20'h40000;
    mx = 0; m1 = 0; m2 = 0; md = 1'b0;
    for (int c = 0; c < 128; c++) begin
      en = (c % 2 == 0);
      tick();
      if (c % 2 == 0) begin
        fb = md ? 64'sd524288 : -64'sd524288;
        n1 = m1 + ((mx - fb) >>> 1);
        n2 = m2 + ((m1 - fb) >>> 1);
        mx = 262144; m1 = n1; m2 = n2; md = (n2 >= 0);
      end
      checks++; if (dout !== md) begin errors++; $display("FAIL gate_dout cycle %0d: got %0b expected %0b", c, dout, md); end
      checks++; if (longint'(dut.i1) !== m1 || longint'(dut.i2) !== m2) begin
        errors++; $display("FAIL gate_integrators cycle %0d: got %0d %0d expected %0d %0d", c, dut.i1, dut.i2, m1, m2);
      end
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL gate_valid cycle %0d: got %0b expected 1", c, dout_valid); end
    end
    en = 1'b1;
  endtask

  task automatic test_overload();
    logic prev;
    int   run, cyc, invalid;
    bit   found;
    apply_reset();
    din = 20'h7FFFF; en = 1'b1;
    prev = 1'b0; run = 1; found = 0; cyc = 0;
    for (int c = 1; c <= 128 && !found; c++) begin
      tick();
      if (dout_valid === 1'b0) begin
        found = 1; cyc = c;
      end else begin
        if (dout === prev) run++; else run = 1;
        prev = dout;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL overload_flush_timeout: got no FLUSH expected within 128 cycles"); end
    checks++; if (cyc !== 36) begin errors++; $display("FAIL overload_flush_cycle: got %0d expected 36", cyc); end
    checks++; if (run !== 32) begin errors++; $display("FAIL overload_run_len: got %0d expected 32", run); end
    checks++; if (recover_cnt !== 8'd1) begin errors++; $display("FAIL overload_recover_cnt: got %0d expected 1", recover_cnt); end
    checks++; if (dut.i1 !== 24'sd0 || dut.i2 !== 24'sd0) begin errors++; $display("FAIL overload_flush_zero: got i1=%0d i2=%0d expected 0 0", dut.i1, dut.i2); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL overload_flush_dout: got %0b expected 0", dout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL overload_ovf: got %0b expected 0", ovf); end
    invalid = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dout_valid === 1'b1) break;
      invalid++;
    end
    checks++; if (invalid !== 9) begin errors++; $display("FAIL overload_invalid_len: got %0d expected 9", invalid); end
    checks++; if (recover_cnt !== 8'd1) begin errors++; $display("FAIL overload_recover_once: got %0d expected 1", recover_cnt); end
  endtask

  task automatic test_reset_midflight();
    bit found;
    found = 0;
    for (int c = 0; c < 128 && !found; c++) begin
      tick();
      if (dout_valid === 1'b0) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_second_flush: got no FLUSH expected within 128 cycles"); end
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    checks++; if (dout !== 1'b0 || dout_valid !== 1'b0 || ovf !== 1'b0 || recover_cnt !== 8'd0) begin
      errors++; $display("FAIL midreset_outputs: got %0b %0b %0b %0d expected 0 0 0 0", dout, dout_valid, ovf, recover_cnt);
    end
    checks++; if (dut.i1 !== 24'sd0 || dut.i2 !== 24'sd0 || dut.x !== 20'sd0) begin
      errors++; $display("FAIL midreset_regs: got i1=%0d i2=%0d x=%0d expected 0 0 0", dut.i1, dut.i2, dut.x);
    end
    checks++; if (dut.state !== 2'd0 || dut.run_len !== 6'd1) begin
      errors++; $display("FAIL midreset_state: got state=%0d run_len=%0d expected 0 1", dut.state, dut.run_len);
    end
    din = '0;
    #1;
    reset_n = 1'b1;
    tick();
    checks++; if (dut.i1 !== 24'sd262144 || dut.i2 !== 24'sd262144) begin
      errors++; $display("FAIL midreset_resume: got i1=%0d i2=%0d expected 262144 262144", dut.i1, dut.i2);
    end
    checks++; if (dout !== 1'b1 || dout_valid !== 1'b1) begin
      errors++; $display("FAIL midreset_resume_out: got dout=%0b valid=%0b expected 1 1", dout, dout_valid);
    end
  endtask

  task automatic test_saturation();
    bit reached;
    int flushes;
    en = 1'b0;
    din21 = 20'h80000; en21 = 1'b1; clr21 = 1'b0;
    reset_n21 = 1'b1;
    for (int e = 1; e <= 37; e++) begin
      clr21 = (e == 15 || e == 37);
      tick();
      if (e == 9) begin
        checks++; if (dut21.i2 !== -21'sd1048576) begin errors++; $display("FAIL sat_edge9_i2: got %0d expected -1048576", dut21.i2); end
        checks++; if (ovf21 !== 1'b0) begin errors++; $display("FAIL sat_edge9_ovf: got %0b expected 0", ovf21); end
      end
      if (e == 10) begin
        checks++; if (dut21.i2 !== -21'sd1048576) begin errors++; $display("FAIL sat_edge10_clamp: got %0d expected -1048576", dut21.i2); end
        checks++; if (ovf21 !== 1'b0) begin errors++; $display("FAIL sat_edge10_ovf: got %0b expected 0", ovf21); end
      end
      if (e == 11) begin
        checks++; if (ovf21 !== 1'b1) begin errors++; $display("FAIL sat_edge11_ovf: got %0b expected 1", ovf21); end
      end
      if (e == 15) begin
        checks++; if (ovf21 !== 1'b1) begin errors++; $display("FAIL sat_clear_vs_set: got %0b expected 1", ovf21); end
      end
      if (e == 35) begin
        checks++; if (dv21 !== 1'b0 || rc21 !== 8'd1) begin errors++; $display("FAIL sat_flush: got valid=%0b cnt=%0d expected 0 1", dv21, rc21); end
      end
      if (e == 36) begin
        checks++; if (ovf21 !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %0b expected 1", ovf21); end
      end
      if (e == 37) begin
        checks++; if (ovf21 !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0b expected 0", ovf21); end
      end
    end
    clr21 = 1'b0;
    din21 = 20'h7FFFF;
    reached = 0;
    for (int c = 0; c < 30000 && !reached; c++) begin
      tick();
      if (rc21 === 8'd255) reached = 1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL sat_cnt_timeout: got %0d expected 255", rc21); end
    flushes = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (dv21 === 1'b0) flushes++;
    end
    checks++; if (flushes == 0) begin errors++; $display("FAIL sat_still_recovering: got %0d invalid cycles expected >0", flushes); end
    checks++; if (rc21 !== 8'd255) begin errors++; $display("FAIL sat_cnt_hold: got %0d expected 255", rc21); end
  endtask

  initial begin
    reset_n21 = 1'b0; en21 = 1'b0; din21 = '0; clr21 = 1'b0;
    test_reset();
    test_zero_input();
    test_half_scale();
    test_enable_gating();
    test_overload();
    test_reset_midflight();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
